// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and helpers for the
// raster timing generator. Default values feed the top-level parameter
// defaults. Derived totals and sync windows are provided here for consumers
// that use the stock mode.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Pin level for a sync given whether it is active and its active polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to the
// sprite renderers and game logic.
//   freeze       : pause request for the animation counters (consumer side)
//   DrawX/DrawY  : raster position
//   blank        : 1 = visible pixel
//   hs/vs        : pipeline-aligned syncs
//   sof          : start-of-frame pulse at (0,0)
//   vblank_start : pulse at the first vertical-blank line
//   frame_count  : frames completed since reset
//   anim_frame   : sprite animation phase
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic        freeze;
    cnt_t        DrawX;
    cnt_t        DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        vblank_start;
    logic [15:0] frame_count;
    logic [3:0]  anim_frame;

    modport master (
        input  freeze,
        output DrawX, DrawY, blank, hs, vs, sof, vblank_start, frame_count, anim_frame
    );

    modport slave (
        output freeze,
        input  DrawX, DrawY, blank, hs, vs, sof, vblank_start, frame_count, anim_frame
    );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// vga_sync_delay: DEPTH-stage delay line for the {hs, vs} pair so the syncs
// leave the block in step with the renderers' registered RGB.
//   clk, reset : clock and synchronous active-high reset
//   d          : raw sync levels {hs, vs}
//   q          : delayed sync levels; DEPTH=0 is a straight wire
module vga_sync_delay #(
    parameter int         DEPTH   = 1,
    parameter logic [1:0] RST_VAL = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] d,
    output logic [1:0] q
);
    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_reg
        logic [1:0] pipe [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
            end else begin
                pipe[0] <= d;
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign q = pipe[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, pipeline-aligned syncs, frame ticks and
// sprite animation phase for the video path.
//   vga_clk : pixel clock
//   reset   : synchronous active-high reset
//   tim     : timing bundle (freeze in; DrawX/DrawY/blank/hs/vs/sof/
//             vblank_start/frame_count/anim_frame out)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int H_FRONT     = H_FRONT_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BACK      = H_BACK_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int V_FRONT     = V_FRONT_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BACK      = V_BACK_DEF,
    parameter bit SYNC_POL    = 1'b0,
    parameter int PIPE_DLY    = 1,
    parameter int ANIM_DIV    = 8,
    parameter int ANIM_FRAMES = 8
) (
    input  logic              vga_clk,
    input  logic              reset,
    vga_timing_gen_if.master  tim
);
    localparam int   H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam int   ADW      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    cnt_t           hc, vc;
    logic [15:0]    frame_count;
    logic [ADW-1:0] anim_div;
    logic [3:0]     anim_frame;

    logic h_end, v_end, hs_act, vs_act;
    logic [1:0] sync_q;

    assign h_end = (hc == H_LAST);
    assign v_end = (vc == V_LAST);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
            anim_div    <= '0;
            anim_frame  <= '0;
        end else if (h_end) begin
            hc <= '0;
            if (v_end) begin
                vc          <= '0;
                frame_count <= frame_count + 16'd1;
                // Animation only moves on the frame wrap so a sprite never
                // changes phase mid-frame.
                if (!tim.freeze) begin
                    if (anim_div == ADW'(ANIM_DIV - 1)) begin
                        anim_div   <= '0;
                        anim_frame <= (anim_frame + 4'd1) & 4'(ANIM_FRAMES - 1);
                    end else begin
                        anim_div <= anim_div + 1'b1;
                    end
                end
            end else begin
                vc <= vc + 1'b1;
            end
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign hs_act = (hc >= HS_START) && (hc <= HS_END);
    assign vs_act = (vc >= VS_START) && (vc <= VS_END);

    vga_sync_delay #(
        .DEPTH   (PIPE_DLY),
        .RST_VAL ({2{~SYNC_POL}})
    ) u_sync_delay (
        .clk   (vga_clk),
        .reset (reset),
        .d     ({sync_level(hs_act, SYNC_POL), sync_level(vs_act, SYNC_POL)}),
        .q     (sync_q)
    );

    assign tim.DrawX        = hc;
    assign tim.DrawY        = vc;
    assign tim.blank        = (hc < cnt_t'(H_VISIBLE)) && (vc < cnt_t'(V_VISIBLE));
    assign tim.sof          = (hc == '0) && (vc == '0);
    assign tim.vblank_start = (hc == '0) && (vc == cnt_t'(V_VISIBLE));
    assign tim.hs           = sync_q[1];
    assign tim.vs           = sync_q[0];
    assign tim.frame_count  = frame_count;
    assign tim.anim_frame   = anim_frame;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster (32x20 totals) so many
// frames fit in a short run. Every cycle the expected outputs are derived
// from the cycle index since reset and pushed to a queue, then popped and
// compared once the DUT has clocked; directed checks cover sync windows,
// frame ticks, animation, freeze and mid-frame reset.
module tb_vga_timing_gen;
    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int ADIV = 8, AFR = 8;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        sof;
        logic        vbs;
        logic [15:0] fc;
        logic [3:0]  anim;
    } obs_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    vga_timing_gen_if bus ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .PIPE_DLY(1), .ANIM_DIV(ADIV), .ANIM_FRAMES(AFR)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .tim     (bus)
    );

    always #20 vga_clk = ~vga_clk;

    int   pass_cnt = 0;
    int   total    = 0;
    obs_t exp_q[$];
    int   t     = 0;   // cycles since the last reset edge
    int   n_adv = 0;   // frame wraps taken with freeze low

    function automatic logic raw_h(int p);
        int h = p % HT;
        return (h >= HV + HF) && (h <= HV + HF + HS - 1);
    endfunction

    function automatic logic raw_v(int p);
        int v = (p / HT) % VT;
        return (v >= VV + VF) && (v <= VV + VF + VS - 1);
    endfunction

    function automatic obs_t model(int tt, int adv);
        obs_t o;
        int h = tt % HT;
        int v = (tt / HT) % VT;
        o.x     = 10'(h);
        o.y     = 10'(v);
        o.blank = (h < HV) && (v < VV);
        o.hs    = (tt == 0) ? 1'b1 : ~raw_h(tt - 1);
        o.vs    = (tt == 0) ? 1'b1 : ~raw_v(tt - 1);
        o.sof   = (h == 0) && (v == 0);
        o.vbs   = (h == 0) && (v == VV);
        o.fc    = 16'(tt / FRAME);
        o.anim  = 4'((adv / ADIV) % AFR);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.x = bus.DrawX; o.y = bus.DrawY; o.blank = bus.blank;
        o.hs = bus.hs; o.vs = bus.vs; o.sof = bus.sof; o.vbs = bus.vblank_start;
        o.fc = bus.frame_count; o.anim = bus.anim_frame;
        return o;
    endfunction

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, want, t);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare popped prediction.
    task automatic step(input logic r, input logic f);
        obs_t got, want;
        reset      = r;
        bus.freeze = f;
        if (r) begin
            t = 0; n_adv = 0;
        end else begin
            if ((t % FRAME) == FRAME - 1 && !f) n_adv++;
            t++;
        end
        exp_q.push_back(model(t, n_adv));
        @(posedge vga_clk);
        @(negedge vga_clk);
        got  = sample();
        want = exp_q.pop_front();
        total++;
        assert (got === want) begin
            pass_cnt++;
        end else begin
            $error("FAIL cyc t=%0d: got x=%0d y=%0d bl=%b hs=%b vs=%b sof=%b vbs=%b fc=%0d an=%0d expected x=%0d y=%0d bl=%b hs=%b vs=%b sof=%b vbs=%b fc=%0d an=%0d",
                   t, got.x, got.y, got.blank, got.hs, got.vs, got.sof, got.vbs, got.fc, got.anim,
                   want.x, want.y, want.blank, want.hs, want.vs, want.sof, want.vbs, want.fc, want.anim);
        end
    endtask

    // Advance to cycle index target. mode 1 holds freeze high throughout;
    // mode 0 pulses freeze mid-frame only, which must have no effect.
    task automatic run_to(input int target, input int mode);
        while (t < target) begin
            int ph = (t + 1) % FRAME;
            step(1'b0, (mode == 1) || (ph >= 100 && ph < 110));
        end
    endtask

    initial begin
        int blank_cnt, hs_low, hs_first, hs_last, vs_low, vs_first_x, vs_first_y, vbs_cnt, sof_cnt;
        bus.freeze = 1'b0;

        // Reset and first-cycle state.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_x", int'(bus.DrawX), 0);
        chk("rst_y", int'(bus.DrawY), 0);
        chk("rst_blank", int'(bus.blank), 1);
        chk("rst_sof", int'(bus.sof), 1);
        chk("rst_hs", int'(bus.hs), 1);
        chk("rst_vs", int'(bus.vs), 1);
        chk("rst_fc", int'(bus.frame_count), 0);
        chk("rst_anim", int'(bus.anim_frame), 0);

        // First line: blank window and hsync window (one cycle late).
        blank_cnt = int'(bus.blank); hs_low = 0; hs_first = -1; hs_last = -1;
        for (int i = 1; i < HT; i++) begin
            step(1'b0, 1'b0);
            if (bus.blank) blank_cnt++;
            if (!bus.hs) begin
                if (hs_first < 0) hs_first = int'(bus.DrawX);
                hs_last = int'(bus.DrawX);
                hs_low++;
            end
        end
        chk("line_blank_cnt", blank_cnt, HV);
        chk("hs_low_cnt", hs_low, HS);
        chk("hs_first_x", hs_first, HV + HF + 1);
        chk("hs_last_x", hs_last, HV + HF + HS);
        step(1'b0, 1'b0);
        chk("wrap_x", int'(bus.DrawX), 0);
        chk("wrap_y", int'(bus.DrawY), 1);

        // Rest of the first frame: vsync window and vblank pulse.
        vs_low = 0; vs_first_x = -1; vs_first_y = -1; vbs_cnt = 0;
        while (t < FRAME - 1) begin
            step(1'b0, 1'b0);
            if (bus.vblank_start) vbs_cnt++;
            if (!bus.vs) begin
                if (vs_first_x < 0) begin
                    vs_first_x = int'(bus.DrawX);
                    vs_first_y = int'(bus.DrawY);
                end
                vs_low++;
            end
        end
        chk("vs_low_cnt", vs_low, VS * HT);
        chk("vs_first_x", vs_first_x, 1);
        chk("vs_first_y", vs_first_y, VV + VF);
        chk("vbs_cnt", vbs_cnt, 1);
        step(1'b0, 1'b0);
        chk("sof_f1", int'(bus.sof), 1);
        chk("fc_f1", int'(bus.frame_count), 1);

        // Count sof pulses over two more frames.
        sof_cnt = 0;
        while (t < 3 * FRAME) begin
            step(1'b0, 1'b0);
            if (bus.sof) sof_cnt++;
        end
        chk("sof_cnt", sof_cnt, 2);
        chk("fc_f3", int'(bus.frame_count), 3);

        // Mid-frame reset at frame 5, x=20, y=10.
        run_to(5 * FRAME + 10 * HT + 20, 0);
        chk("pre_rst_fc", int'(bus.frame_count), 5);
        chk("pre_rst_x", int'(bus.DrawX), 20);
        step(1'b1, 1'b0);
        chk("mrst_x", int'(bus.DrawX), 0);
        chk("mrst_y", int'(bus.DrawY), 0);
        chk("mrst_fc", int'(bus.frame_count), 0);
        chk("mrst_sof", int'(bus.sof), 1);
        chk("mrst_hs", int'(bus.hs), 1);
        chk("mrst_vs", int'(bus.vs), 1);

        // Animation stepping every ADIV frames, wrapping after AFR phases.
        run_to(8 * FRAME - 1, 0);
        chk("anim_f7", int'(bus.anim_frame), 0);
        run_to(8 * FRAME, 0);
        chk("anim_f8", int'(bus.anim_frame), 1);
        run_to(16 * FRAME, 0);
        chk("anim_f16", int'(bus.anim_frame), 2);
        run_to(63 * FRAME, 0);
        chk("anim_f63", int'(bus.anim_frame), 7);
        run_to(64 * FRAME, 0);
        chk("anim_f64", int'(bus.anim_frame), 0);

        // Freeze across frame wraps 65..80: phase holds.
        run_to(80 * FRAME, 1);
        chk("anim_frz", int'(bus.anim_frame), 0);
        chk("fc_frz", int'(bus.frame_count), 80);
        run_to(87 * FRAME, 0);
        chk("anim_f87", int'(bus.anim_frame), 0);
        run_to(88 * FRAME, 0);
        chk("anim_f88", int'(bus.anim_frame), 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
